// File: rtl/ocd_inject_sequencer_pkg.sv
// Shared types for the debugger instruction-inject sequencer.
// Status codes, FSM states and a saturating attempt counter helper.
package ocd_inject_sequencer_pkg;

   typedef enum logic [1:0] {
      INJ_OK              = 2'd0,
      INJ_RETRY_EXHAUSTED = 2'd1,
      INJ_TIMEOUT         = 2'd2
   } inject_status_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      RESPOND = 2'd3
   } inject_seq_state_t;

   localparam int INST_W = 32;
   localparam int ATT_W  = 3;

   function automatic logic [ATT_W-1:0] sat_inc_att(logic [ATT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/ocd_inject_sequencer_if.sv
// Host request/response and core inject/complete/rollback bundle.
// slave = sequencer side, master = debugger host plus core side.
interface ocd_inject_sequencer_if;

   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_inst;
   logic        resp_valid;
   logic        resp_ready;
   logic [1:0]  resp_status;
   logic [2:0]  resp_attempts;
   logic        ocd_halt;
   logic [31:0] ocd_inject_inst;
   logic        ocd_inject_en;
   logic        injected_complete;
   logic        injected_rollback;
   logic        busy;

   modport slave (
      input  req_valid, req_inst, resp_ready,
      input  ocd_halt, injected_complete, injected_rollback,
      output req_ready, resp_valid, resp_status, resp_attempts,
      output ocd_inject_inst, ocd_inject_en, busy
   );

   modport master (
      output req_valid, req_inst, resp_ready,
      output ocd_halt, injected_complete, injected_rollback,
      input  req_ready, resp_valid, resp_status, resp_attempts,
      input  ocd_inject_inst, ocd_inject_en, busy
   );

endinterface

// File: rtl/ocd_inject_fifo.sv
// Synchronous FIFO holding pending injected instructions.
// DEPTH must be a power of two; pointers wrap naturally.
module ocd_inject_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (cnt_q == DEPTH_C);
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rd_q];
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   // Pointer and occupancy next state.
   always_comb begin
      wr_d  = push_ok ? wr_q + 1'b1 : wr_q;
      rd_d  = pop_ok ? rd_q + 1'b1 : rd_q;
      cnt_d = cnt_q;
      if (push_ok && !pop_ok) cnt_d = cnt_q + 1'b1;
      if (!push_ok && pop_ok) cnt_d = cnt_q - 1'b1;
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset; occupancy guards every read.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/ocd_inject_sequencer.sv
// Debugger instruction-inject sequencer with rollback reissue.
// Optional per-attempt timeout is built when OCD_INJECT_TIMEOUT_EN is defined.
module ocd_inject_sequencer
   import ocd_inject_sequencer_pkg::*;
#(
   parameter int MAX_RETRIES    = 3,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                clk,
   input  logic                reset,
   ocd_inject_sequencer_if.slave bus
);

   localparam logic [ATT_W-1:0] MAX_R = ATT_W'(MAX_RETRIES);

   inject_seq_state_t state_q, state_d;
   inject_status_t    status_q, status_d;
   logic [INST_W-1:0] cur_q, cur_d;
   logic [ATT_W-1:0]  att_q, att_d;
   logic              inj_en;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [INST_W-1:0] fifo_head;
   logic              resp_vld;

`ifdef OCD_INJECT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] timer_q, timer_d;
`endif

   ocd_inject_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (INST_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (bus.req_valid),
      .data_i  (bus.req_inst),
      .pop_i   (pop),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign resp_vld            = (state_q == RESPOND);
   assign bus.req_ready       = !fifo_full;
   assign bus.resp_valid      = resp_vld;
   assign bus.resp_status     = resp_vld ? status_q : INJ_OK;
   assign bus.resp_attempts   = resp_vld ? att_q : '0;
   assign bus.ocd_inject_en   = inj_en;
   assign bus.ocd_inject_inst = inj_en ? cur_q : '0;
   assign bus.busy            = (state_q != IDLE) || !fifo_empty;

   // Next state, inject strobe and pop; rollback > complete > timeout.
   always_comb begin
      state_d  = state_q;
      status_d = status_q;
      cur_d    = cur_q;
      att_d    = att_q;
      inj_en   = 1'b0;
      pop      = 1'b0;
`ifdef OCD_INJECT_TIMEOUT_EN
      timer_d  = timer_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty && bus.ocd_halt) begin
               pop     = 1'b1;
               cur_d   = fifo_head;
               att_d   = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // A dropped halt stalls here rather than injecting.
            if (bus.ocd_halt) begin
               inj_en  = 1'b1;
               att_d   = sat_inc_att(att_q);
`ifdef OCD_INJECT_TIMEOUT_EN
               timer_d = '0;
`endif
               state_d = WAIT;
            end
         end
         WAIT: begin
`ifdef OCD_INJECT_TIMEOUT_EN
            timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
`endif
            if (bus.injected_rollback) begin
               if (att_q <= MAX_R) begin
                  state_d = ISSUE;
               end else begin
                  status_d = INJ_RETRY_EXHAUSTED;
                  state_d  = RESPOND;
               end
            end else if (bus.injected_complete) begin
               status_d = INJ_OK;
               state_d  = RESPOND;
`ifdef OCD_INJECT_TIMEOUT_EN
            end else if (timer_q == T_LAST) begin
               status_d = INJ_TIMEOUT;
               state_d  = RESPOND;
`endif
            end
         end
         RESPOND: begin
            if (bus.resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         status_q <= INJ_OK;
         cur_q    <= '0;
         att_q    <= '0;
`ifdef OCD_INJECT_TIMEOUT_EN
         timer_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         status_q <= status_d;
         cur_q    <= cur_d;
         att_q    <= att_d;
`ifdef OCD_INJECT_TIMEOUT_EN
         timer_q  <= timer_d;
`endif
      end
   end

endmodule

// File: tb/tb_ocd_inject_sequencer.sv
// Directed self-checking bench for ocd_inject_sequencer.
// Covers latency, retries, FIFO ordering/backpressure, timeout and reset.
module tb_ocd_inject_sequencer;
   import ocd_inject_sequencer_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   base;
   int   n;
   logic [31:0] inj_q [$];

   ocd_inject_sequencer_if bus ();

   ocd_inject_sequencer #(
      .MAX_RETRIES    (3),
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.ocd_inject_en === 1'b1) inj_q.push_back(bus.ocd_inject_inst);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] d);
      chk("push_ready", {31'd0, bus.req_ready}, 32'd1);
      bus.req_valid = 1'b1;
      bus.req_inst  = d;
      tick();
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_inj(input string tag);
      int k = 0;
      while (bus.ocd_inject_en !== 1'b1 && k < 10) begin
         tick();
         k++;
      end
      chk(tag, {31'd0, bus.ocd_inject_en}, 32'd1);
   endtask

   task automatic accept();
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
      chk("resp_drop", {31'd0, bus.resp_valid}, 32'd0);
   endtask

   task automatic complete_accept(input string tag, input logic [1:0] st,
                                  input logic [2:0] att);
      tick();
      bus.injected_complete = 1'b1;
      tick();
      bus.injected_complete = 1'b0;
      chk({tag, "_valid"}, {31'd0, bus.resp_valid}, 32'd1);
      chk({tag, "_status"}, {30'd0, bus.resp_status}, {30'd0, st});
      chk({tag, "_att"}, {29'd0, bus.resp_attempts}, {29'd0, att});
      accept();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
      chk({tag, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
      chk({tag, "_status"}, {30'd0, bus.resp_status}, 32'd0);
      chk({tag, "_att"}, {29'd0, bus.resp_attempts}, 32'd0);
      chk({tag, "_inj_en"}, {31'd0, bus.ocd_inject_en}, 32'd0);
      chk({tag, "_inj_inst"}, bus.ocd_inject_inst, 32'd0);
      chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid         = 1'b0;
      bus.req_inst          = '0;
      bus.resp_ready        = 1'b0;
      bus.ocd_halt          = 1'b0;
      bus.injected_complete = 1'b0;
      bus.injected_rollback = 1'b0;
      tick();
      tick();
      chk_reset_vals("rst");
      reset = 1'b0;
      tick();
      chk_reset_vals("post_rst");

      // Basic inject: 2-cycle push-to-inject, complete 3 cycles later.
      bus.ocd_halt = 1'b1;
      base = inj_q.size();
      push(32'h1234_5678);
      tick();
      chk("lat_en", {31'd0, bus.ocd_inject_en}, 32'd1);
      chk("lat_inst", bus.ocd_inject_inst, 32'h1234_5678);
      tick();
      chk("one_strobe", {31'd0, bus.ocd_inject_en}, 32'd0);
      tick();
      tick();
      chk("wait_novalid", {31'd0, bus.resp_valid}, 32'd0);
      bus.injected_complete = 1'b1;
      tick();
      bus.injected_complete = 1'b0;
      chk("ok_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("ok_status", {30'd0, bus.resp_status}, 32'd0);
      chk("ok_att", {29'd0, bus.resp_attempts}, 32'd1);
      chk("ok_nstrobe", inj_q.size() - base, 32'd1);
      accept();
      chk("ok_idle", {31'd0, bus.busy}, 32'd0);

      // Rollback on every attempt: 4 strobes then RETRY_EXHAUSTED.
      base = inj_q.size();
      push(32'hA5A5_0001);
      wait_inj("rb_first");
      for (int i = 0; i < 4; i++) begin
         tick();
         bus.injected_rollback = 1'b1;
         tick();
         bus.injected_rollback = 1'b0;
         if (i < 3) chk("rb_reissue", {31'd0, bus.ocd_inject_en}, 32'd1);
      end
      chk("rb_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("rb_status", {30'd0, bus.resp_status}, 32'd1);
      chk("rb_att", {29'd0, bus.resp_attempts}, 32'd4);
      chk("rb_nstrobe", inj_q.size() - base, 32'd4);
      accept();

      // Rollback on first attempt only.
      base = inj_q.size();
      push(32'hA5A5_0002);
      wait_inj("rb1_first");
      tick();
      bus.injected_rollback = 1'b1;
      tick();
      bus.injected_rollback = 1'b0;
      chk("rb1_reissue", {31'd0, bus.ocd_inject_en}, 32'd1);
      complete_accept("rb1", 2'd0, 3'd2);
      chk("rb1_nstrobe", inj_q.size() - base, 32'd2);

      // Complete and rollback together: rollback wins.
      push(32'hA5A5_0003);
      wait_inj("both_first");
      tick();
      bus.injected_rollback = 1'b1;
      bus.injected_complete = 1'b1;
      tick();
      bus.injected_rollback = 1'b0;
      bus.injected_complete = 1'b0;
      chk("both_novalid", {31'd0, bus.resp_valid}, 32'd0);
      chk("both_reissue", {31'd0, bus.ocd_inject_en}, 32'd1);
      complete_accept("both", 2'd0, 3'd2);

      // Fill FIFO while not halted; 5th push waits for first pop.
      bus.ocd_halt = 1'b0;
      base = inj_q.size();
      for (int i = 0; i < 4; i++) push(32'hC000_0000 + i);
      chk("full_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("full_busy", {31'd0, bus.busy}, 32'd1);
      bus.req_valid = 1'b1;
      bus.req_inst  = 32'hC000_0004;
      tick();
      chk("full_hold", {31'd0, bus.req_ready}, 32'd0);
      chk("nohalt_nostrobe", inj_q.size() - base, 32'd0);
      bus.ocd_halt = 1'b1;
      tick();
      chk("pop_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("pop_inj", bus.ocd_inject_inst, 32'hC000_0000);
      tick();
      bus.req_valid = 1'b0;
      bus.injected_complete = 1'b1;
      tick();
      bus.injected_complete = 1'b0;
      chk("f0_valid", {31'd0, bus.resp_valid}, 32'd1);
      accept();
      for (int i = 1; i < 5; i++) begin
         wait_inj("fifo_inj");
         complete_accept("fifo", 2'd0, 3'd1);
      end
      chk("fifo_nstrobe", inj_q.size() - base, 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (base + i < inj_q.size())
            chk("fifo_order", inj_q[base+i], 32'hC000_0000 + i);
      end
      chk("fifo_idle", {31'd0, bus.busy}, 32'd0);

      // No core response: timeout or indefinite wait.
      push(32'hD000_0001);
      wait_inj("tmo_inj");
      n = 0;
      while (bus.resp_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
`ifdef OCD_INJECT_TIMEOUT_EN
      chk("tmo_lat", n, 32'd17);
      chk("tmo_status", {30'd0, bus.resp_status}, 32'd2);
      chk("tmo_att", {29'd0, bus.resp_attempts}, 32'd1);
      accept();
      push(32'hD000_0002);
      wait_inj("rst_inj");
      tick();
`else
      chk("notmo_valid", {31'd0, bus.resp_valid}, 32'd0);
      chk("notmo_busy", {31'd0, bus.busy}, 32'd1);
`endif

      // Reset mid-WAIT with two queued.
      push(32'hE000_0001);
      push(32'hE000_0002);
      chk("prerst_busy", {31'd0, bus.busy}, 32'd1);
      reset = 1'b1;
      #2;
      chk_reset_vals("midrst");
      tick();
      reset = 1'b0;
      base = inj_q.size();
      bus.injected_complete = 1'b1;
      tick();
      bus.injected_complete = 1'b0;
      tick();
      tick();
      chk("late_cmp_novalid", {31'd0, bus.resp_valid}, 32'd0);
      chk("late_cmp_busy", {31'd0, bus.busy}, 32'd0);
      chk("late_cmp_nostrobe", inj_q.size() - base, 32'd0);

      // Fresh transaction after reset.
      push(32'hF000_0001);
      wait_inj("post_inj");
      chk("post_inst", bus.ocd_inject_inst, 32'hF000_0001);
      complete_accept("post", 2'd0, 3'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
